// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, RAM port and perf counters.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  if_req_i;
  logic [DATA_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [INST_WIDTH-1:0] if_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [DATA_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [2:0]            d_wid_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [2:0]            mem_wid_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic [31:0]           perf_conflict_o;
  logic [31:0]           perf_if_stall_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wid_o,
    output perf_conflict_o, perf_if_stall_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wid_o,
    input  perf_conflict_o, perf_if_stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data-first with
// anti-starvation for fetch. Define MEM_ARB_PERF_CNT_EN to build the perf counters.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned INST_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned StreakW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [StreakW-1:0] StarveLim = StreakW'(STARVE_LIMIT);
  localparam logic [2:0] WidWord = 3'b010;

  typedef enum logic [1:0] {StIdle, StRespIf, StRespD} state_e;

  state_e             r_state;
  logic [StreakW-1:0] r_streak;
  logic               r_if_rvalid;
  logic               r_d_rvalid;

  logic w_starve;
  logic w_if_gnt;
  logic w_d_gnt;

  assign w_starve = (r_streak == StarveLim);

  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst_i) begin
      w_if_gnt = bus.if_req_i && (!bus.d_req_i || w_starve);
      w_d_gnt  = bus.d_req_i && !w_if_gnt;
    end
  end

  always_comb begin
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_wid_o   = 3'b000;
    if (w_if_gnt) begin
      bus.mem_addr_o = bus.if_addr_i;
      bus.mem_wid_o  = WidWord;
    end else if (w_d_gnt) begin
      bus.mem_we_o    = bus.d_we_i;
      bus.mem_addr_o  = bus.d_addr_i;
      bus.mem_wdata_o = bus.d_wdata_i;
      bus.mem_wid_o   = bus.d_wid_i;
    end
  end

  assign bus.mem_en_o = w_if_gnt | w_d_gnt;
  assign bus.if_gnt_o = w_if_gnt;
  assign bus.d_gnt_o  = w_d_gnt;

  // State records who owns the read returning next cycle; stores complete at grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_streak    <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      if (w_if_gnt) begin
        r_state     <= StRespIf;
        r_if_rvalid <= 1'b1;
        r_d_rvalid  <= 1'b0;
      end else if (w_d_gnt && !bus.d_we_i) begin
        r_state     <= StRespD;
        r_if_rvalid <= 1'b0;
        r_d_rvalid  <= 1'b1;
      end else begin
        r_state     <= StIdle;
        r_if_rvalid <= 1'b0;
        r_d_rvalid  <= 1'b0;
      end

      if (!bus.if_req_i || w_if_gnt) begin
        r_streak <= '0;
      end else if (w_d_gnt && !w_starve) begin
        r_streak <= r_streak + StreakW'(1);
      end
    end
  end

  assign bus.if_rvalid_o = r_if_rvalid && (r_state == StRespIf);
  assign bus.d_rvalid_o  = r_d_rvalid && (r_state == StRespD);
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i[INST_WIDTH-1:0] : '0;
  assign bus.d_rdata_o   = bus.d_rvalid_o ? bus.mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_if_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_conflict <= '0;
      r_perf_if_stall <= '0;
    end else begin
      r_perf_conflict <= r_perf_conflict + 32'(bus.if_req_i & bus.d_req_i);
      r_perf_if_stall <= r_perf_if_stall + 32'(bus.if_req_i & ~w_if_gnt);
    end
  end

  assign bus.perf_conflict_o = r_perf_conflict;
  assign bus.perf_if_stall_o = r_perf_if_stall;
`else
  assign bus.perf_conflict_o = '0;
  assign bus.perf_if_stall_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus held-request random
// traffic checked against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .STARVE_LIMIT(SL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

`ifdef MEM_ARB_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Model state: current (m_) and value after the coming clock edge (n_).
  // pend: 0 = no read outstanding, 1 = fetch read, 2 = data read.
  int          m_streak, n_streak, m_pend, n_pend;
  logic [31:0] m_conf, n_conf, m_stall, n_stall;

  logic          e_if_gnt, e_d_gnt, e_en, e_we, e_if_rv, e_d_rv;
  logic [2:0]    e_wid;
  logic [DW-1:0] e_addr, e_wdata, e_d_rd;
  logic [IW-1:0] e_if_rd;
  logic [31:0]   e_conf, e_stall;

  task automatic model_clear();
    m_streak = 0; n_streak = 0; m_pend = 0; n_pend = 0;
    m_conf = '0; n_conf = '0; m_stall = '0; n_stall = '0;
  endtask

  task automatic model_eval();
    e_if_gnt = !rst && bus.if_req_i && (!bus.d_req_i || m_streak == SL);
    e_d_gnt  = !rst && bus.d_req_i && !e_if_gnt;
    e_en     = e_if_gnt || e_d_gnt;
    e_we     = e_d_gnt && bus.d_we_i;
    e_addr   = e_if_gnt ? bus.if_addr_i : (e_d_gnt ? bus.d_addr_i : '0);
    e_wdata  = e_d_gnt ? bus.d_wdata_i : '0;
    e_wid    = e_if_gnt ? 3'b010 : (e_d_gnt ? bus.d_wid_i : 3'b000);
    e_if_rv  = (m_pend == 1);
    e_d_rv   = (m_pend == 2);
    e_if_rd  = e_if_rv ? bus.mem_rdata_i[IW-1:0] : '0;
    e_d_rd   = e_d_rv ? bus.mem_rdata_i : '0;
    e_conf   = PerfEn ? m_conf : '0;
    e_stall  = PerfEn ? m_stall : '0;
    n_pend   = e_if_gnt ? 1 : ((e_d_gnt && !bus.d_we_i) ? 2 : 0);
    if (!bus.if_req_i || e_if_gnt) n_streak = 0;
    else if (e_d_gnt && m_streak < SL) n_streak = m_streak + 1;
    else n_streak = m_streak;
    n_conf  = m_conf + ((bus.if_req_i && bus.d_req_i) ? 32'd1 : 32'd0);
    n_stall = m_stall + ((bus.if_req_i && !e_if_gnt) ? 32'd1 : 32'd0);
    if (rst) begin
      n_streak = 0; n_pend = 0; n_conf = '0; n_stall = '0;
    end
  endtask

  task automatic set_idle();
    bus.if_req_i  = 1'b0; bus.if_addr_i = '0;
    bus.d_req_i   = 1'b0; bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;   bus.d_wdata_i = '0; bus.d_wid_i = 3'b000;
  endtask

  // One cycle: drive at the falling edge, settle, then evaluate the model.
  task automatic drive_cycle(input logic ir, input logic [DW-1:0] ia, input logic dr,
                             input logic dwe, input logic [DW-1:0] da,
                             input logic [DW-1:0] dwd, input logic [2:0] dwid);
    @(negedge clk);
    m_streak = n_streak; m_pend = n_pend; m_conf = n_conf; m_stall = n_stall;
    bus.if_req_i = ir;  bus.if_addr_i = ia;
    bus.d_req_i  = dr;  bus.d_we_i    = dwe; bus.d_addr_i = da;
    bus.d_wdata_i = dwd; bus.d_wid_i  = dwid;
    bus.mem_rdata_i = {$urandom(), $urandom()};
    #1;
    model_eval();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0, '0, 3'b000);
    @(posedge clk);
    #2;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 64'h44;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({bus.if_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o,
         bus.if_rvalid_o, bus.d_rvalid_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.if_gnt_o, bus.d_gnt_o, bus.mem_en_o,
               bus.mem_we_o, bus.mem_wid_o, bus.if_rvalid_o, bus.d_rvalid_o});
    end
    checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.d_rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h exp=0", bus.mem_addr_o, bus.mem_wdata_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.perf_conflict_o, bus.perf_if_stall_o, bus.mem_en_o, bus.if_rvalid_o} !== '0) begin
      errors++;
      $display("FAIL reset_hold got conf=%0d stall=%0d en=%b rv=%b exp=0", bus.perf_conflict_o,
               bus.perf_if_stall_o, bus.mem_en_o, bus.if_rvalid_o);
    end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
  endtask

  task automatic test_lone_fetch();
    reset_dut();
    drive_cycle(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if ({bus.if_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o} !== 7'b1010010
        || bus.mem_addr_o !== 64'h8000_0000) begin
      errors++;
      $display("FAIL fetch_grant got gnt/en/we/wid=%b addr=%h exp=1010010 80000000",
               {bus.if_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o},
               bus.mem_addr_o);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== bus.mem_rdata_i[31:0]
        || bus.d_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp got rv=%b rdata=%h exp rv=1 rdata=%h", bus.if_rvalid_o,
               bus.if_rdata_o, bus.mem_rdata_i[31:0]);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if (bus.if_rvalid_o !== 1'b0 || bus.if_rdata_o !== '0) begin
      errors++;
      $display("FAIL fetch_once got rv=%b rdata=%h exp 0 0", bus.if_rvalid_o, bus.if_rdata_o);
    end
  endtask

  task automatic test_conflict();
    reset_dut();
    drive_cycle(1'b1, 64'h8000_0100, 1'b1, 1'b0, 64'h1000, '0, 3'b010);
    checks++;
    if ({bus.d_gnt_o, bus.if_gnt_o, bus.mem_we_o} !== 3'b100 || bus.mem_addr_o !== 64'h1000) begin
      errors++;
      $display("FAIL conflict_grant got d/if/we=%b addr=%h exp=100 1000",
               {bus.d_gnt_o, bus.if_gnt_o, bus.mem_we_o}, bus.mem_addr_o);
    end
    drive_cycle(1'b1, 64'h8000_0100, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if (bus.d_rvalid_o !== 1'b1 || bus.d_rdata_o !== bus.mem_rdata_i || bus.if_gnt_o !== 1'b1
        || bus.mem_addr_o !== 64'h8000_0100) begin
      errors++;
      $display("FAIL conflict_next got drv=%b drd=%h ifg=%b exp 1 %h 1", bus.d_rvalid_o,
               bus.d_rdata_o, bus.if_gnt_o, bus.mem_rdata_i);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if ({bus.if_rvalid_o, bus.d_rvalid_o} !== 2'b10) begin
      errors++;
      $display("FAIL conflict_ifresp got if/d rv=%b exp=10", {bus.if_rvalid_o, bus.d_rvalid_o});
    end
  endtask

  task automatic test_starvation();
    logic [5:0] if_seq, d_seq;
    reset_dut();
    if_seq = '0; d_seq = '0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 64'h8000_0200, 1'b1, 1'b0, 64'h3000, '0, 3'b011);
      if_seq = {if_seq[4:0], bus.if_gnt_o};
      d_seq  = {d_seq[4:0], bus.d_gnt_o};
    end
    checks++;
    if ({if_seq, d_seq} !== 12'b000010_111101) begin
      errors++;
      $display("FAIL starvation got if=%b d=%b exp if=000010 d=111101", if_seq, d_seq);
    end
  endtask

  task automatic test_store();
    reset_dut();
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 64'h2000, 64'hDEAD_BEEF, 3'b011);
    checks++;
    if ({bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o} !== 6'b111011
        || bus.mem_wdata_o !== 64'hDEAD_BEEF || bus.mem_addr_o !== 64'h2000) begin
      errors++;
      $display("FAIL store_grant got g/en/we/wid=%b wdata=%h exp=111011 deadbeef",
               {bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o}, bus.mem_wdata_o);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if (bus.d_rvalid_o !== 1'b0 || bus.d_rdata_o !== '0) begin
      errors++;
      $display("FAIL store_norv got rv=%b rdata=%h exp 0 0", bus.d_rvalid_o, bus.d_rdata_o);
    end
  endtask

  task automatic test_reset_mid_read();
    reset_dut();
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 64'h1008, '0, 3'b011);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    model_clear();
    #1;
    checks++;
    if (bus.d_rvalid_o !== 1'b0 || bus.d_rdata_o !== '0) begin
      errors++;
      $display("FAIL midrd_rst got rv=%b rdata=%h exp 0 0", bus.d_rvalid_o, bus.d_rdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
      checks++;
      if ({bus.d_rvalid_o, bus.if_rvalid_o} !== 2'b00) begin
        errors++;
        $display("FAIL midrd_after%0d got d/if rv=%b exp=00", i,
                 {bus.d_rvalid_o, bus.if_rvalid_o});
      end
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_cnt;
    reset_dut();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 64'h8000_0000, 1'b1, 1'b1, 64'h40, 64'h5, 3'b011);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    exp_cnt = PerfEn ? 32'd3 : 32'd0;
    checks++;
    if (bus.perf_conflict_o !== exp_cnt || bus.perf_if_stall_o !== exp_cnt) begin
      errors++;
      $display("FAIL perf_cnt got conf=%0d stall=%0d exp=%0d", bus.perf_conflict_o,
               bus.perf_if_stall_o, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic          ir, dr, dwe;
    logic [DW-1:0] ia, da, dwd;
    logic [2:0]    dwid;
    logic          prev_if_gnt, prev_d_gnt;
    reset_dut();
    ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = '0; da = '0; dwd = '0; dwid = '0;
    prev_if_gnt = 1'b1; prev_d_gnt = 1'b1;
    for (int c = 0; c < 400; c++) begin
      // Ungranted requests are held with stable payload, as a real requester would.
      if (!(ir && !prev_if_gnt)) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = {$urandom(), $urandom()};
      end
      if (!(dr && !prev_d_gnt)) begin
        dr   = ($urandom_range(0, 3) != 0);
        dwe  = $urandom_range(0, 1) == 1;
        da   = {$urandom(), $urandom()};
        dwd  = {$urandom(), $urandom()};
        dwid = 3'($urandom_range(0, 7));
      end
      drive_cycle(ir, ia, dr, dwe, da, dwd, dwid);
      prev_if_gnt = bus.if_gnt_o;
      prev_d_gnt  = bus.d_gnt_o;
      checks++;
      if ({bus.if_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o}
          !== {e_if_gnt, e_d_gnt, e_en, e_we, e_wid}) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c, {bus.if_gnt_o, bus.d_gnt_o,
                 bus.mem_en_o, bus.mem_we_o, bus.mem_wid_o}, {e_if_gnt, e_d_gnt, e_en, e_we, e_wid});
      end
      checks++;
      if (bus.mem_addr_o !== e_addr || bus.mem_wdata_o !== e_wdata) begin
        errors++;
        $display("FAIL rnd_bus cyc=%0d got=%h/%h exp=%h/%h", c, bus.mem_addr_o, bus.mem_wdata_o,
                 e_addr, e_wdata);
      end
      checks++;
      if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.if_rdata_o, bus.d_rdata_o}
          !== {e_if_rv, e_d_rv, e_if_rd, e_d_rd}) begin
        errors++;
        $display("FAIL rnd_resp cyc=%0d got rv=%b%b exp rv=%b%b", c, bus.if_rvalid_o,
                 bus.d_rvalid_o, e_if_rv, e_d_rv);
      end
      checks++;
      if (bus.perf_conflict_o !== e_conf || bus.perf_if_stall_o !== e_stall) begin
        errors++;
        $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.perf_conflict_o,
                 bus.perf_if_stall_o, e_conf, e_stall);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    bus.mem_rdata_i = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_lone_fetch();
    test_conflict();
    test_starvation();
    test_store();
    test_reset_mid_read();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 64, data and address width; INST_WIDTH, default 32, fetch data width; STARVE_LIMIT, default 4, maximum consecutive data grants while fetch waits.
REQ-002 SHALL have ports (clock and reset first):
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  fetch request.
- if_addr_i  in  DATA_WIDTH  fetch PC.
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  INST_WIDTH  fetch data, equal to mem_rdata_i[INST_WIDTH-1:0].
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  DATA_WIDTH  data address.
- d_wdata_i  in  DATA_WIDTH  store data.
- d_wid_i  in  3  access width/sign code, passed through unchanged.
- d_gnt_o  out  1  data accepted this cycle.
- d_rvalid_o  out  1  load data valid.
- d_rdata_o  out  DATA_WIDTH  load data.
- mem_en_o  out  1  RAM access enable.
- mem_we_o  out  1  RAM write.
- mem_addr_o  out  DATA_WIDTH  RAM address.
- mem_wdata_o  out  DATA_WIDTH  RAM write data.
- mem_wid_o  out  3  RAM width code.
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en_o with mem_we_o=0.
- perf_conflict_o  out  32  count of cycles with both requests asserted.
- perf_if_stall_o  out  32  count of cycles with if_req_i asserted and if_gnt_o low.

Function
REQ-003 SHALL arbitrate one single-port synchronous RAM between the fetch and data requesters, granting at most one request per cycle.
REQ-004 SHALL combinationally drive grant and mem_* in the request cycle: mem_en_o = if_gnt_o | d_gnt_o; address, data, write and width come from the granted requester.
REQ-005 SHALL drive mem_we_o=0 and mem_wid_o=3'b010 (word) for fetch grants.
REQ-006 SHALL drive mem_addr_o, mem_wdata_o, mem_we_o and mem_wid_o to 0 when no grant is given.
REQ-007 SHALL give priority to data (the older instruction) when both requests are asserted, unless the starvation rule applies.
REQ-008 SHALL keep a saturating streak counter, incremented on each data grant while if_req_i=1 and cleared on any fetch grant or any cycle with if_req_i=0.
REQ-009 SHALL grant fetch over data when the streak counter equals STARVE_LIMIT.
REQ-010 SHALL track the owner of the in-flight read with FSM states IDLE, RESP_IF and RESP_D.
- Next state: RESP_IF after a fetch grant; RESP_D after a load grant; otherwise IDLE (a store grant also yields IDLE).
REQ-011 SHALL assert if_rvalid_o only in RESP_IF and d_rvalid_o only in RESP_D, exactly one cycle after the grant, with rdata taken from mem_rdata_i.
REQ-012 SHALL permit a new grant in the same cycle a response returns, sustaining one access per cycle.
REQ-013 SHALL produce no rvalid for stores; a store completes at grant.
REQ-014 SHALL treat requests as level signals: a request not granted is held by the requester with stable address and data; the arbiter keeps no request queue.
REQ-015 SHALL set rdata outputs to 0 whenever the matching rvalid is low.

Reset
REQ-016 SHALL on rst_i assertion, independent of clk_i, set FSM=IDLE, streak counter=0 and perf counters=0, and force every grant, rvalid and mem_* output to 0 while rst_i=1.
REQ-017 SHALL discard any response in flight when rst_i is asserted mid-operation; no rvalid follows reset deassertion.

Configuration
REQ-018 SHALL compile in, when macro MEM_ARB_PERF_CNT_EN is defined, two 32-bit wrapping counters driving perf_conflict_o and perf_if_stall_o, incrementing per the REQ-002 definitions.
REQ-019 SHALL, when MEM_ARB_PERF_CNT_EN is undefined, keep both perf ports present but tied to 0 and include no counter flops.

Verification
REQ-020 SHALL cover a lone fetch: if_req_i=1, if_addr_i=0x80000000 -> if_gnt_o=1 and mem_addr_o=0x80000000 the same cycle; if_rvalid_o=1 next cycle with if_rdata_o=mem_rdata_i[31:0].
REQ-021 SHALL cover a conflict: both requests asserted, d_we_i=0, d_addr_i=0x1000 -> d_gnt_o=1, if_gnt_o=0; next cycle d_rvalid_o=1 and if_gnt_o=1.
REQ-022 SHALL cover starvation: both requests held for 6 cycles with STARVE_LIMIT=4 -> grants D,D,D,D,IF,D.
REQ-023 SHALL cover a store: d_we_i=1, d_wdata_i=0xDEADBEEF, d_wid_i=3'b011 -> mem_we_o=1, mem_wid_o=3'b011 in the grant cycle; no d_rvalid_o next cycle.
REQ-024 SHALL cover reset mid-read: rst_i asserted the cycle after a load grant -> d_rvalid_o stays 0 and FSM=IDLE after release.
REQ-025 SHALL cover counters: with the macro defined, 3 conflict cycles -> perf_conflict_o=3 and perf_if_stall_o=3; without the macro, both read 0.
